uart_cmd_sequencer: RTL and testbench

Byte-level command controller that sits behind the UART core. It pops received bytes from the Rx FIFO and parses fixed 5-byte command frames. It executes register writes and reads on a local register bank, then queues ACK/NAK responses into the Tx FIFO, replacing the push-button read/write handshake with an autonomous sequencer.

---
 rtl/uart_cmd_sequencer_pkg.sv | 14 +
 rtl/uart_cmd_sequencer_if.sv | 14 +
 rtl/uart_cmd_regbank.sv | 48 ++++
 rtl/uart_cmd_sequencer.sv | 145 ++++++++++++++
 tb/tb_uart_cmd_sequencer.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_cmd_sequencer_pkg.sv
// Shared types and constants for the UART command sequencer.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    ST_SYNC, ST_CMD, ST_ADDR, ST_DATA, ST_CHK, ST_EXEC, ST_RESP0, ST_RESP1
  } state_e;

  localparam logic [7:0] CMD_WR    = 8'h57;
  localparam logic [7:0] CMD_RD    = 8'h52;
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_cmd_sequencer_if.sv
// Rx/Tx FIFO handshake bundle; master = sequencer, slave = FIFO side.
interface uart_cmd_if #(parameter int DBITS = 8);
  logic             rx_empty;
  logic [DBITS-1:0] read_data;
  logic             read_uart;
  logic             tx_full;
  logic             write_uart;
  logic [DBITS-1:0] write_data;

  modport master (input rx_empty, read_data, tx_full,
                  output read_uart, write_uart, write_data);
  modport slave  (output rx_empty, read_data, tx_full,
                  input read_uart, write_uart, write_data);
endinterface

// File: rtl/uart_cmd_regbank.sv
// Register bank: bounds-checked write port, combinational read, flattened view.
module uart_cmd_regbank #(
  parameter int DBITS     = 8,
  parameter int REG_COUNT = 8,
  parameter int ADDR_BITS = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_wr_en,
  input  logic [DBITS-1:0]           i_addr,
  input  logic [DBITS-1:0]           i_wdata,
  output logic                       o_addr_ok,
  output logic [DBITS-1:0]           o_rd_data,
  output logic [REG_COUNT*DBITS-1:0] o_reg_q,
  output logic                       o_reg_wr,
  output logic [ADDR_BITS-1:0]       o_reg_wr_addr
);

  logic [REG_COUNT-1:0][DBITS-1:0] r_regs;
  logic                            r_reg_wr;
  logic [ADDR_BITS-1:0]            r_reg_wr_addr;
  logic [ADDR_BITS-1:0]            w_idx;
  logic                            w_we;

  // Full field width is compared so high address bits cannot alias into range.
  assign o_addr_ok     = int'(i_addr) < REG_COUNT;
  assign w_idx         = i_addr[ADDR_BITS-1:0];
  assign w_we          = i_wr_en && o_addr_ok;
  assign o_rd_data     = o_addr_ok ? r_regs[w_idx] : '0;
  assign o_reg_q       = r_regs;
  assign o_reg_wr      = r_reg_wr;
  assign o_reg_wr_addr = r_reg_wr_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regs        <= '0;
      r_reg_wr      <= 1'b0;
      r_reg_wr_addr <= '0;
    end else begin
      r_reg_wr <= w_we;
      if (w_we) begin
        r_regs[w_idx] <= i_wdata;
        r_reg_wr_addr <= w_idx;
      end
    end
  end

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Parses 5-byte SYNC/CMD/ADDR/DATA/CHK frames from the Rx FIFO and answers ACK/NAK.
// Define CMD_TIMEOUT_EN to enable the inter-byte timeout counter.
module uart_cmd_sequencer #(
  parameter int         DBITS          = 8,
  parameter int         REG_COUNT      = 8,
  parameter int         ADDR_BITS      = 3,
  parameter logic [7:0] SYNC_BYTE      = uart_cmd_pkg::SYNC_BYTE,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter int         TO_BITS        = 20
) (
  input  logic                       clk_100MHz,
  input  logic                       reset,
  uart_cmd_if.master                 fifo,
  output logic [REG_COUNT*DBITS-1:0] reg_q,
  output logic                       reg_wr,
  output logic [ADDR_BITS-1:0]       reg_wr_addr,
  output logic                       busy,
  output logic                       frame_err,
  output logic                       timeout_err
);
  import uart_cmd_pkg::*;

  if (DBITS != 8) begin : g_bad_dbits
    $error("uart_cmd_sequencer supports DBITS=8 only");
  end
  if ((1 << ADDR_BITS) < REG_COUNT) begin : g_bad_addr
    $error("ADDR_BITS too narrow for REG_COUNT");
  end
  if (TO_BITS < 31 && (1 << TO_BITS) < TIMEOUT_CYCLES) begin : g_bad_to
    $error("TO_BITS too narrow for TIMEOUT_CYCLES");
  end

  state_e           r_state, w_state_nxt;
  logic             r_rd_prev, r_wr_prev;
  logic [DBITS-1:0] r_cmd, r_addr, r_data, r_chk, r_rdata;
  logic             r_ok, r_is_rd, r_frame_err;
  logic             w_parse, w_pop, w_push, w_exec, w_exec_ok, w_wr_en, w_addr_ok, w_to_hit;
  logic [DBITS-1:0] w_rd_data;

  assign w_parse   = (r_state == ST_CMD) || (r_state == ST_ADDR) ||
                     (r_state == ST_DATA) || (r_state == ST_CHK);
  // Strobes are never back-to-back so the FIFO flags have a cycle to settle.
  assign w_pop     = ((r_state == ST_SYNC) || w_parse) && !fifo.rx_empty && !r_rd_prev;
  assign w_push    = ((r_state == ST_RESP0) || (r_state == ST_RESP1)) && !fifo.tx_full && !r_wr_prev;
  assign w_exec    = (r_state == ST_EXEC);
  assign w_exec_ok = (r_chk == (r_cmd ^ r_addr ^ r_data)) &&
                     ((r_cmd == CMD_WR) || (r_cmd == CMD_RD)) && w_addr_ok;
  assign w_wr_en   = w_exec && w_exec_ok && (r_cmd == CMD_WR);

  assign fifo.read_uart  = w_pop;
  assign fifo.write_uart = w_push;
  assign fifo.write_data = !w_push ? '0 :
                           (r_state == ST_RESP1) ? r_rdata :
                           r_ok ? RSP_ACK : RSP_NAK;
  assign busy      = (r_state != ST_SYNC);
  assign frame_err = r_frame_err;

  uart_cmd_regbank #(.DBITS(DBITS), .REG_COUNT(REG_COUNT), .ADDR_BITS(ADDR_BITS)) u_regbank (
    .clk           (clk_100MHz),
    .rst_n         (reset),
    .i_wr_en       (w_wr_en),
    .i_addr        (r_addr),
    .i_wdata       (r_data),
    .o_addr_ok     (w_addr_ok),
    .o_rd_data     (w_rd_data),
    .o_reg_q       (reg_q),
    .o_reg_wr      (reg_wr),
    .o_reg_wr_addr (reg_wr_addr)
  );

`ifdef CMD_TIMEOUT_EN
  localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(TIMEOUT_CYCLES - 1);
  logic [TO_BITS-1:0] r_to_cnt;
  logic               r_timeout_err;

  assign w_to_hit    = w_parse && fifo.rx_empty && (r_to_cnt == TO_LAST);
  assign timeout_err = r_timeout_err;

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      r_to_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_to_hit;
      if (!w_parse || w_pop || w_to_hit) r_to_cnt <= '0;
      else if (fifo.rx_empty)            r_to_cnt <= r_to_cnt + 1'b1;
    end
  end
`else
  assign w_to_hit    = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_SYNC:  if (w_pop && fifo.read_data == SYNC_BYTE) w_state_nxt = ST_CMD;
      ST_CMD:   if (w_pop) w_state_nxt = ST_ADDR;
      ST_ADDR:  if (w_pop) w_state_nxt = ST_DATA;
      ST_DATA:  if (w_pop) w_state_nxt = ST_CHK;
      ST_CHK:   if (w_pop) w_state_nxt = ST_EXEC;
      ST_EXEC:  w_state_nxt = ST_RESP0;
      ST_RESP0: if (w_push) w_state_nxt = (r_ok && r_is_rd) ? ST_RESP1 : ST_SYNC;
      ST_RESP1: if (w_push) w_state_nxt = ST_SYNC;
      default:  w_state_nxt = ST_SYNC;
    endcase
    if (w_to_hit) w_state_nxt = ST_SYNC;
  end

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_SYNC;
      r_rd_prev   <= 1'b0;
      r_wr_prev   <= 1'b0;
      r_cmd       <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_chk       <= '0;
      r_rdata     <= '0;
      r_ok        <= 1'b0;
      r_is_rd     <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rd_prev   <= w_pop;
      r_wr_prev   <= w_push;
      r_frame_err <= w_exec && !w_exec_ok;
      if (w_pop) begin
        case (r_state)
          ST_CMD:  r_cmd  <= fifo.read_data;
          ST_ADDR: r_addr <= fifo.read_data;
          ST_DATA: r_data <= fifo.read_data;
          ST_CHK:  r_chk  <= fifo.read_data;
          default: ;
        endcase
      end
      if (w_exec) begin
        r_ok    <= w_exec_ok;
        r_is_rd <= (r_cmd == CMD_RD);
        r_rdata <= w_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Directed plus randomized frames against a byte-stream reference model and FIFO emulation.
module tb_uart_cmd_sequencer;
  import uart_cmd_pkg::*;

  localparam int RC = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_cmd_if #(.DBITS(8)) bus();
  logic [RC*8-1:0] reg_q;
  logic            reg_wr;
  logic [2:0]      reg_wr_addr;
  logic            busy, frame_err, timeout_err;

  uart_cmd_sequencer #(.DBITS(8), .REG_COUNT(RC), .ADDR_BITS(3), .TIMEOUT_CYCLES(100), .TO_BITS(20)) dut (
    .clk_100MHz  (clk),
    .reset       (rst_n),
    .fifo        (bus),
    .reg_q       (reg_q),
    .reg_wr      (reg_wr),
    .reg_wr_addr (reg_wr_addr),
    .busy        (busy),
    .frame_err   (frame_err),
    .timeout_err (timeout_err)
  );

  int vectors = 0;
  int miscompares = 0;

  // FIFO emulation and monitor
  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  int         pop_cyc[$];
  int         push_cyc[$];
  int         cyc = 0;
  int         n_wr = 0, n_ferr = 0, n_to = 0;
  int         wr_cyc = -1, to_cyc = -1;
  logic [2:0] last_wr_addr = 3'd0;
  logic       pop_pend = 1'b0;

  always @(posedge clk) begin
    cyc++;
    #1;
    if (pop_pend && rxq.size() > 0) void'(rxq.pop_front());
    pop_pend = 1'b0;
    bus.rx_empty  = (rxq.size() == 0);
    bus.read_data = (rxq.size() > 0) ? rxq[0] : 8'h00;
  end

  always @(negedge clk) begin
    pop_pend = bus.read_uart;
    if (bus.read_uart) pop_cyc.push_back(cyc);
    if (bus.write_uart) begin
      txq.push_back(bus.write_data);
      push_cyc.push_back(cyc);
    end
    if (reg_wr) begin
      n_wr++;
      wr_cyc = cyc;
      last_wr_addr = reg_wr_addr;
    end
    if (frame_err) n_ferr++;
    if (timeout_err) begin
      n_to++;
      to_cyc = cyc;
    end
  end

  // Reference model: frame-level interpretation of the byte stream
  logic [7:0] mregs[RC];
  logic [7:0] fb[$];
  logic [7:0] exp_tx[$];
  int         exp_wr = 0, exp_ferr = 0;

  function automatic void model_byte(input logic [7:0] b);
    logic [7:0] c, a, d, k;
    if (fb.size() == 0 && b != SYNC_BYTE) return;
    fb.push_back(b);
    if (fb.size() < 5) return;
    c = fb[1]; a = fb[2]; d = fb[3]; k = fb[4];
    fb.delete();
    if (k != (c ^ a ^ d) || (c != 8'h57 && c != 8'h52) || int'(a) >= RC) begin
      exp_tx.push_back(8'h15);
      exp_ferr++;
    end else if (c == 8'h57) begin
      mregs[a[2:0]] = d;
      exp_wr++;
      exp_tx.push_back(8'h06);
    end else begin
      exp_tx.push_back(8'h06);
      exp_tx.push_back(mregs[a[2:0]]);
    end
  endfunction

  function automatic logic [63:0] model_q();
    logic [63:0] q;
    for (int i = 0; i < RC; i++) q[8*i +: 8] = mregs[i];
    return q;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [7:0] b);
    rxq.push_back(b);
    model_byte(b);
  endtask

  task automatic frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d, input logic [7:0] k);
    put(SYNC_BYTE); put(c); put(a); put(d); put(k);
  endtask

  logic rnd_bp = 1'b0;

  task automatic settle(input int maxcyc);
    int idle = 0;
    for (int i = 0; i < maxcyc && idle < 4; i++) begin
      @(posedge clk); #2;
      if (rnd_bp) bus.tx_full = ($urandom_range(0, 3) == 0);
      idle = (rxq.size() == 0 && !busy && !bus.write_uart) ? idle + 1 : 0;
    end
    bus.tx_full = 1'b0;
    chk("settle", 64'(idle >= 4), 64'd1);
  endtask

  task automatic check_all(input string tag);
    int n = (txq.size() < exp_tx.size()) ? txq.size() : exp_tx.size();
    chk({tag, "_txcnt"}, 64'(txq.size()), 64'(exp_tx.size()));
    for (int i = 0; i < n; i++) chk({tag, "_txbyte"}, 64'(txq[i]), 64'(exp_tx[i]));
    chk({tag, "_regq"}, reg_q, model_q());
    chk({tag, "_nwr"}, 64'(n_wr), 64'(exp_wr));
    chk({tag, "_nferr"}, 64'(n_ferr), 64'(exp_ferr));
    txq.delete(); exp_tx.delete();
  endtask

  task automatic clr_times();
    pop_cyc.delete(); push_cyc.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] c, a, d, k, b;
    int kind, ng;
    for (int i = 0; i < RC; i++) mregs[i] = 8'h00;
    bus.rx_empty = 1'b1; bus.read_data = 8'h00; bus.tx_full = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_read_uart", 64'(bus.read_uart), 64'd0);
    chk("rst_write_uart", 64'(bus.write_uart), 64'd0);
    chk("rst_reg_q", reg_q, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_pulses", {61'd0, reg_wr, frame_err, timeout_err}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #2;

    // write A5 57 02 3C 69
    clr_times();
    frame(8'h57, 8'h02, 8'h3C, 8'h69);
    settle(200);
    chk("wr_addr", 64'(last_wr_addr), 64'd2);
    chk("wr_pop_spacing", 64'(pop_cyc[4] - pop_cyc[0]), 64'd8);
    chk("wr_chk_to_push", 64'(push_cyc[0] - pop_cyc[4]), 64'd2);
    chk("wr_regq_before_ack", 64'(wr_cyc), 64'(push_cyc[0]));
    check_all("write");

    // read A5 52 02 00 50
    clr_times();
    frame(8'h52, 8'h02, 8'h00, 8'h50);
    settle(200);
    chk("rd_push_spacing", 64'(push_cyc[1] - push_cyc[0]), 64'd2);
    check_all("read");

    frame(8'h57, 8'h01, 8'h11, 8'h00);
    settle(200);
    check_all("bad_chk");
    frame(8'h57, 8'h09, 8'hFF, 8'hA1);
    settle(200);
    check_all("bad_addr");
    frame(8'h41, 8'h00, 8'h00, 8'h41);
    settle(200);
    check_all("bad_cmd");

    // backpressure with leading garbage
    bus.tx_full = 1'b1;
    put(8'h00); put(8'hFF);
    frame(8'h52, 8'h02, 8'h00, 8'h50);
    repeat (50) @(posedge clk);
    #2;
    chk("bp_no_push", 64'(txq.size()), 64'd0);
    chk("bp_busy", 64'(busy), 64'd1);
    chk("bp_rx_drained", 64'(rxq.size()), 64'd0);
    bus.tx_full = 1'b0;
    settle(200);
    check_all("backpressure");

`ifdef CMD_TIMEOUT_EN
    clr_times();
    put(SYNC_BYTE); put(8'h57);
    repeat (160) @(posedge clk);
    #2;
    chk("to_count", 64'(n_to), 64'd1);
    chk("to_latency", 64'(to_cyc - pop_cyc[1]), 64'd101);
    chk("to_no_push", 64'(txq.size()), 64'd0);
    chk("to_busy", 64'(busy), 64'd0);
    fb.delete();
    frame(8'h57, 8'h05, 8'h77, 8'h57 ^ 8'h05 ^ 8'h77);
    settle(200);
    check_all("after_timeout");
`endif

    // asynchronous reset mid-frame
    put(SYNC_BYTE); put(8'h57);
    repeat (10) @(posedge clk);
    #2;
    chk("mid_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_regq", reg_q, 64'd0);
    for (int i = 0; i < RC; i++) mregs[i] = 8'h00;
    fb.delete();
    @(posedge clk); #2;
    rst_n = 1'b1;
    frame(8'h57, 8'h07, 8'hA5, 8'h57 ^ 8'h07 ^ 8'hA5);
    settle(200);
    check_all("after_reset");

    // randomized frames with occasional backpressure
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 4);
      ng = $urandom_range(0, 2);
      for (int g = 0; g < ng; g++) begin
        b = 8'($urandom_range(0, 255));
        if (b == SYNC_BYTE) b = 8'h00;
        put(b);
      end
      a = 8'($urandom_range(0, RC - 1));
      d = 8'($urandom_range(0, 255));
      c = ($urandom_range(0, 1) == 1) ? 8'h57 : 8'h52;
      if (kind == 0) c = 8'h57;
      if (kind == 1) c = 8'h52;
      if (kind == 3) a = 8'($urandom_range(RC, 255));
      if (kind == 4) begin
        c = 8'($urandom_range(0, 255));
        if (c == 8'h57 || c == 8'h52) c = 8'h00;
      end
      k = c ^ a ^ d;
      if (kind == 2) k = k ^ 8'($urandom_range(1, 255));
      frame(c, a, d, k);
      rnd_bp = (n % 3 == 0);
      settle(600);
      rnd_bp = 1'b0;
      check_all("random");
    end

`ifndef CMD_TIMEOUT_EN
    chk("no_timeout", 64'(n_to), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
